fcvt_int_fp: RTL and testbench

- Multi-cycle converter between IEEE-754 single precision and 32-bit integers, covering RISC-V FCVT.W.S, FCVT.WU.S, FCVT.S.W and FCVT.S.WU.
- Sits beside fadd_fsub in the FPU execute stage; the FPU controller issues it with an En pulse and waits for Done.
- Normalisation and denormalisation run one bit-shift per cycle, trading latency for area.
- Rounding is fixed round-toward-zero (RTZ); no rm input.

---
 rtl/fcvt_int_fp_if.sv | 16 +
 rtl/fcvt_int_fp.sv | 144 ++++++++++++++
 tb/tb_fcvt_int_fp.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fcvt_int_fp_if.sv
// rtl/fcvt_int_fp_if.sv - Request/result bundle between the FPU controller and the int/float converter
interface fcvt_int_fp_if #(
  parameter int XLEN = 32
);
  logic            En;
  logic [1:0]      Op;
  logic [XLEN-1:0] src;
  logic            Ready;
  logic            Done;
  logic [XLEN-1:0] frd;
  logic            flag_nv;
  logic            flag_nx;

  modport master (output En, Op, src, input Ready, Done, frd, flag_nv, flag_nx);
  modport slave  (input En, Op, src, output Ready, Done, frd, flag_nv, flag_nx);
endinterface

// File: rtl/fcvt_int_fp.sv
// rtl/fcvt_int_fp.sv - Bit-serial FCVT.W.S / WU.S / S.W / S.WU converter, round-toward-zero
module fcvt_int_fp #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  fcvt_int_fp_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;

  logic [XLEN-1:0] shreg;
  logic            sticky;
  logic [4:0]      cnt;
  logic            i2f_r, special_r, left_r, neg_r, nv_r;
  logic [XLEN-1:0] frd_r;
  logic            nv_o, nx_o;

  logic            a_sign;
  logic [7:0]      a_exp;
  logic [XLEN-1:0] a_man, a_mag, a_val;
  logic            a_special, a_left, a_neg, a_nv, a_nx;
  logic [4:0]      a_cnt;
  logic            shift_more;
  logic [7:0]      exp_w;

  assign a_sign = bus.src[31];
  assign a_exp  = bus.src[30:23];
  assign a_man  = {8'd0, |a_exp, bus.src[22:0]};
  assign a_mag  = (!bus.Op[0] && a_sign) ? (32'd0 - bus.src) : bus.src;

  // Specials resolve fully at accept; their final result rides in a_val with N=0.
  always_comb begin
    a_special = 1'b1;
    a_left    = 1'b0;
    a_neg     = 1'b0;
    a_nv      = 1'b0;
    a_nx      = 1'b0;
    a_val     = '0;
    a_cnt     = '0;
    if (bus.Op[1]) begin
      a_neg     = !bus.Op[0] && a_sign;
      a_val     = a_mag;
      a_special = (a_mag == '0);
    end else if (a_exp == 8'hFF && |bus.src[22:0]) begin
      a_nv  = 1'b1;
      a_val = bus.Op[0] ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
    end else if (!bus.Op[0] && bus.src == 32'hCF00_0000) begin
      a_val = 32'h8000_0000;
    end else if (!bus.Op[0] && a_exp >= 8'd158) begin
      a_nv  = 1'b1;
      a_val = a_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (bus.Op[0] && a_sign && a_exp >= 8'd127) begin
      a_nv  = 1'b1;
    end else if (bus.Op[0] && a_exp >= 8'd159) begin
      a_nv  = 1'b1;
      a_val = 32'hFFFF_FFFF;
    end else if (a_exp < 8'd127) begin
      a_nx = |bus.src[30:0];
    end else begin
      a_special = 1'b0;
      a_val     = a_man;
      a_neg     = !bus.Op[0] && a_sign;
      a_left    = (a_exp > 8'd150);
      a_cnt     = a_left ? 5'(a_exp - 8'd150) : 5'(8'd150 - a_exp);
    end
  end

  // Int->float normalises until the MSB is set; float->int runs the loaded count down.
  assign shift_more = !special_r && (i2f_r ? !shreg[31] : (cnt != 5'd0));
  assign exp_w      = 8'd158 - {3'd0, cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.En) state_nx = SHIFT;
      SHIFT:   if (!shift_more) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      sticky    <= 1'b0;
      cnt       <= '0;
      i2f_r     <= 1'b0;
      special_r <= 1'b0;
      left_r    <= 1'b0;
      neg_r     <= 1'b0;
      nv_r      <= 1'b0;
      frd_r     <= '0;
      nv_o      <= 1'b0;
      nx_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.En) begin
          shreg     <= a_val;
          sticky    <= a_nx;
          cnt       <= a_cnt;
          i2f_r     <= bus.Op[1];
          special_r <= a_special;
          left_r    <= a_left;
          neg_r     <= a_neg;
          nv_r      <= a_nv;
        end
        SHIFT: if (shift_more) begin
          if (i2f_r || left_r) begin
            shreg <= shreg << 1;
          end else begin
            shreg  <= shreg >> 1;
            sticky <= sticky | shreg[0];
          end
          cnt <= i2f_r ? cnt + 5'd1 : cnt - 5'd1;
        end else begin
          nv_o <= nv_r;
          if (special_r) begin
            frd_r <= shreg;
            nx_o  <= sticky;
          end else if (i2f_r) begin
            frd_r <= {neg_r, exp_w, shreg[30:8]};
            nx_o  <= |shreg[7:0];
          end else begin
            frd_r <= neg_r ? (32'd0 - shreg) : shreg;
            nx_o  <= sticky;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Ready   = (state == IDLE);
  assign bus.Done    = (state == DONE);
  assign bus.frd     = frd_r;
  assign bus.flag_nv = nv_o;
  assign bus.flag_nx = nx_o;
endmodule

// File: tb/tb_fcvt_int_fp.sv
// tb/tb_fcvt_int_fp.sv - Randomised and directed bench for fcvt_int_fp against an arithmetic reference
module tb_fcvt_int_fp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  fcvt_int_fp_if #(.XLEN(32)) bus ();
  fcvt_int_fp #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] src;
    logic [31:0] res;
    logic        nv;
    logic        nx;
    int          lat;
  } vec_t;

  // Reference: exact truncated value and range tests for float->int, leading-one search for int->float.
  task automatic model(input logic [1:0] op, input logic [31:0] s,
                       output logic [31:0] r, output logic nv, output logic nx, output int lat);
    int          e;
    int          p;
    logic        sg, fr, huge;
    logic [63:0] man, ip, mag, mant;
    r = '0; nv = 1'b0; nx = 1'b0; lat = 1;
    if (!op[1]) begin
      sg   = s[31];
      e    = int'(s[30:23]);
      man  = {40'd0, (e != 0), s[22:0]};
      huge = (e >= 190);
      fr   = 1'b0;
      if (e >= 150) ip = man << (e - 150);
      else begin
        ip = man >> (150 - e);
        fr = ((ip << (150 - e)) != man);
      end
      if (e == 255 && s[22:0] != 0) begin
        nv = 1'b1;
        r  = op[0] ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
      end else if (!op[0]) begin
        if (huge || (!sg && ip > 64'h7FFF_FFFF) || (sg && ip > 64'h8000_0000)) begin
          nv = 1'b1;
          r  = sg ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
          r  = sg ? (32'd0 - ip[31:0]) : ip[31:0];
          nx = fr;
        end
      end else begin
        if (sg && (huge || ip != 0)) begin
          nv = 1'b1;
          r  = 32'd0;
        end else if (huge || ip > 64'hFFFF_FFFF) begin
          nv = 1'b1;
          r  = 32'hFFFF_FFFF;
        end else begin
          r  = ip[31:0];
          nx = fr;
        end
      end
      if (!nv && e >= 127 && s != 32'hCF00_0000) lat = 1 + ((e > 150) ? e - 150 : 150 - e);
    end else begin
      sg  = !op[0] && s[31];
      mag = {32'd0, s};
      if (sg) mag = 64'h1_0000_0000 - mag;
      if (mag != 0) begin
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        if (p >= 23) begin
          mant = mag >> (p - 23);
          nx   = ((mant << (p - 23)) != mag);
        end else begin
          mant = mag << (23 - p);
        end
        r   = {sg, 8'(127 + p), mant[22:0]};
        lat = 1 + (31 - p);
      end
    end
  endtask

  // Issue one request; lat counts edges after the accept edge until Done is seen.
  task automatic conv(input logic [1:0] op, input logic [31:0] s, input bit hold,
                      output logic [31:0] r, output logic nv, output logic nx, output int lat,
                      output bit to, output bit rdy_bad, output bit frd_moved);
    logic [31:0] prev;
    int          w;
    w = 0;
    @(negedge clk);
    while (!bus.Ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    prev = bus.frd;
    bus.En = 1'b1; bus.Op = op; bus.src = s;
    @(posedge clk); #1;
    if (!hold) begin
      bus.En = 1'b0; bus.Op = 2'($urandom); bus.src = $urandom;
    end
    lat = 0; to = 1'b0; rdy_bad = 1'b0; frd_moved = 1'b0;
    while (!bus.Done && !to) begin
      if (bus.Ready) rdy_bad = 1'b1;
      if (bus.frd !== prev) frd_moved = 1'b1;
      @(posedge clk); #1;
      lat++;
      if (lat >= 40) to = !bus.Done;
    end
    if (bus.Ready) rdy_bad = 1'b1;
    r = bus.frd; nv = bus.flag_nv; nx = bus.flag_nx;
    if (hold) begin
      @(negedge clk);
      bus.En = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.Ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.Ready); end
    checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.Done); end
    checks++; if (bus.frd !== 32'h0) begin errors++; $display("FAIL reset_frd: got %h expected 00000000", bus.frd); end
    checks++; if ({bus.flag_nv, bus.flag_nx} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got %b expected 00", {bus.flag_nv, bus.flag_nx});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    vec_t        v[15];
    logic [31:0] r;
    logic        nv, nx;
    int          lat;
    bit          to, rb, fm;
    v[0]  = '{2'd0, 32'h40490FDB, 32'h00000003, 1'b0, 1'b1, 23};
    v[1]  = '{2'd0, 32'hCF000000, 32'h80000000, 1'b0, 1'b0, 1};
    v[2]  = '{2'd0, 32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1};
    v[3]  = '{2'd0, 32'h7FC00000, 32'h7FFFFFFF, 1'b1, 1'b0, 1};
    v[4]  = '{2'd1, 32'hBF000000, 32'h00000000, 1'b0, 1'b1, 1};
    v[5]  = '{2'd1, 32'hBF800000, 32'h00000000, 1'b1, 1'b0, 1};
    v[6]  = '{2'd1, 32'h4F800000, 32'hFFFFFFFF, 1'b1, 1'b0, 1};
    v[7]  = '{2'd2, 32'hFFFFFFFF, 32'hBF800000, 1'b0, 1'b0, 32};
    v[8]  = '{2'd2, 32'h7FFFFFFF, 32'h4EFFFFFF, 1'b0, 1'b1, 2};
    v[9]  = '{2'd2, 32'h80000000, 32'hCF000000, 1'b0, 1'b0, 1};
    v[10] = '{2'd2, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1};
    v[11] = '{2'd3, 32'hFFFFFFFF, 32'h4F7FFFFF, 1'b0, 1'b1, 1};
    v[12] = '{2'd0, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1};
    v[13] = '{2'd1, 32'h7FC00000, 32'hFFFFFFFF, 1'b1, 1'b0, 1};
    v[14] = '{2'd0, 32'hC0490FDB, 32'hFFFFFFFD, 1'b0, 1'b1, 23};
    foreach (v[i]) begin
      conv(v[i].op, v[i].src, 1'b0, r, nv, nx, lat, to, rb, fm);
      checks++; if (to) begin errors++; $display("FAIL dir%0d_timeout: got no Done expected Done", i); end
      checks++; if (r !== v[i].res) begin errors++; $display("FAIL dir%0d_frd: got %h expected %h", i, r, v[i].res); end
      checks++; if (nv !== v[i].nv) begin errors++; $display("FAIL dir%0d_nv: got %b expected %b", i, nv, v[i].nv); end
      checks++; if (nx !== v[i].nx) begin errors++; $display("FAIL dir%0d_nx: got %b expected %b", i, nx, v[i].nx); end
      checks++; if (lat != v[i].lat) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] s, r, er;
    logic        nv, nx, env, enx;
    int          lat, elat;
    bit          to, rb, fm;
    for (int n = 0; n < 200; n++) begin
      op = 2'($urandom);
      if (!op[1]) begin
        case ($urandom % 4)
          0:       s = $urandom;
          1:       s = {1'($urandom), 8'($urandom_range(120, 165)), 23'($urandom)};
          2:       s = {1'($urandom), 8'($urandom_range(150, 160)), 23'($urandom)};
          default: s = {1'($urandom), 8'($urandom_range(125, 135)), 23'($urandom)};
        endcase
      end else begin
        s = $urandom >> $urandom_range(0, 31);
        if ($urandom % 2) s = 32'd0 - s;
      end
      model(op, s, er, env, enx, elat);
      conv(op, s, 1'b0, r, nv, nx, lat, to, rb, fm);
      checks++; if (to) begin errors++; $display("FAIL rnd%0d_timeout: op %0d src %h got no Done", n, op, s); end
      checks++; if (r !== er) begin errors++; $display("FAIL rnd%0d_frd: op %0d src %h got %h expected %h", n, op, s, r, er); end
      checks++; if ({nv, nx} !== {env, enx}) begin
        errors++; $display("FAIL rnd%0d_flags: op %0d src %h got nv,nx=%b expected %b", n, op, s, {nv, nx}, {env, enx});
      end
      checks++; if (lat != elat) begin errors++; $display("FAIL rnd%0d_latency: op %0d src %h got %0d expected %0d", n, op, s, lat, elat); end
      checks++; if (rb || fm) begin
        errors++; $display("FAIL rnd%0d_protocol: got ready_high=%b frd_moved=%b expected 0 0", n, rb, fm);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, er;
    logic        nv, nx, env, enx;
    int          lat, elat, extra;
    bit          to, rb, fm;
    model(2'd2, 32'h0001_2345, er, env, enx, elat);
    conv(2'd2, 32'h0001_2345, 1'b1, r, nv, nx, lat, to, rb, fm);
    checks++; if (to || r !== er) begin errors++; $display("FAIL hold_frd: got %h expected %h", r, er); end
    checks++; if (lat != elat) begin errors++; $display("FAIL hold_latency: got %0d expected %0d", lat, elat); end
    checks++; if (rb) begin errors++; $display("FAIL hold_ready_low: got Ready high during conversion expected low"); end
    @(posedge clk); #1;
    checks++; if (bus.Done !== 1'b0 || bus.Ready !== 1'b1) begin
      errors++; $display("FAIL done_one_cycle: got Done=%b Ready=%b expected 0 1", bus.Done, bus.Ready);
    end
    extra = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.Done || !bus.Ready) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL single_conversion: got %0d busy cycles expected 0", extra); end
    model(2'd3, 32'h0000_0001, er, env, enx, elat);
    conv(2'd3, 32'h0000_0001, 1'b0, r, nv, nx, lat, to, rb, fm);
    checks++; if (fm) begin errors++; $display("FAIL frd_held: got frd change before Done expected none"); end
    checks++; if (to || r !== er || lat != elat) begin
      errors++; $display("FAIL b2b_second: got %h lat %0d expected %h lat %0d", r, lat, er, elat);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic        nv, nx;
    int          lat, seen;
    bit          to, rb, fm;
    conv(2'd2, 32'h0000_0001, 1'b0, r, nv, nx, lat, to, rb, fm);
    checks++; if (to || r !== 32'h3F80_0000) begin errors++; $display("FAIL pre_reset_frd: got %h expected 3f800000", r); end
    @(negedge clk);
    bus.En = 1'b1; bus.Op = 2'd2; bus.src = 32'h0000_0001;
    @(posedge clk); #1;
    bus.En = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.Ready !== 1'b1 || bus.Done !== 1'b0) begin
      errors++; $display("FAIL midreset_ctrl: got Ready=%b Done=%b expected 1 0", bus.Ready, bus.Done);
    end
    checks++; if (bus.frd !== 32'h0 || bus.flag_nv !== 1'b0 || bus.flag_nx !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got frd=%h nv=%b nx=%b expected 0 0 0", bus.frd, bus.flag_nv, bus.flag_nx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.Done) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midreset_no_done: got %0d Done pulses expected 0", seen); end
    conv(2'd0, 32'h4049_0FDB, 1'b0, r, nv, nx, lat, to, rb, fm);
    checks++; if (to || r !== 32'h3 || nx !== 1'b1 || nv !== 1'b0 || lat != 23) begin
      errors++; $display("FAIL post_reset_conv: got %h nv=%b nx=%b lat %0d expected 00000003 0 1 23", r, nv, nx, lat);
    end
  endtask

  initial begin
    bus.En = 1'b0; bus.Op = 2'd0; bus.src = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
